// File: rtl/lif_pkg.sv
// Shared definitions for the leaky-integrate-and-fire scheduler.
// Contents:
//   STATE_W / REFRAC_W : membrane state width and refractory counter width
//   lif_state_e        : scheduler FSM states (IDLE, UPDATE, FINISH)
//   leak()             : 8-bit leak, (s>>1)+(s>>2)+(s>>3), every shift truncates
//   sat8()             : 9-bit sum of two 8-bit values, clamped to 255
package lif_pkg;

  localparam int STATE_W  = 8;
  localparam int REFRAC_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    FINISH = 2'd2
  } lif_state_e;

  // The largest possible result is 127+63+31 = 221, so the sum cannot wrap.
  function automatic logic [STATE_W-1:0] leak(input logic [STATE_W-1:0] s);
    return (s >> 1) + (s >> 2) + (s >> 3);
  endfunction

  function automatic logic [STATE_W-1:0] sat8(input logic [STATE_W-1:0] a,
                                              input logic [STATE_W-1:0] b);
    logic [STATE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STATE_W] ? {STATE_W{1'b1}} : sum[STATE_W-1:0];
  endfunction

endpackage

// File: rtl/lif_scheduler_if.sv
// Bus between the current source / learning logic and lif_scheduler.
// Signals:
//   tick        start-of-timestep pulse
//   current_in  packed per-neuron input current, neuron i at [8i+7:8i]
//   cfg_we      threshold write strobe, cfg_thresh the value written
//   rd_sel      neuron index for membrane state readback
//   busy        timestep in progress
//   done        one-cycle pulse when spike_vec is updated
//   spike_vec   spikes of the last completed timestep
//   rd_state    membrane state of neuron rd_sel
//   overrun     sticky flag: a tick arrived while a timestep was running
// Modports: master drives requests/configuration, slave is the scheduler.
interface lif_scheduler_if #(
  parameter int NUM_NEURONS = 4
) ();

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                     tick;
  logic [8*NUM_NEURONS-1:0] current_in;
  logic                     cfg_we;
  logic [7:0]               cfg_thresh;
  logic [IDX_W-1:0]         rd_sel;
  logic                     busy;
  logic                     done;
  logic [NUM_NEURONS-1:0]   spike_vec;
  logic [7:0]               rd_state;
  logic                     overrun;

  modport master (
    output tick, current_in, cfg_we, cfg_thresh, rd_sel,
    input  busy, done, spike_vec, rd_state, overrun
  );

  modport slave (
    input  tick, current_in, cfg_we, cfg_thresh, rd_sel,
    output busy, done, spike_vec, rd_state, overrun
  );

endinterface

// File: rtl/lif_core.sv
// Shared combinational LIF update datapath, used once per clock for one neuron.
// Ports:
//   s      stored membrane state       new_s  updated membrane state
//   c      captured input current      new_r  updated refractory count
//   r      refractory count            spike  neuron fires this timestep
//   thr    threshold for this timestep
module lif_core
  import lif_pkg::*;
#(
  parameter int REFRAC_TICKS = 2
) (
  input  logic [STATE_W-1:0]  s,
  input  logic [STATE_W-1:0]  c,
  input  logic [REFRAC_W-1:0] r,
  input  logic [STATE_W-1:0]  thr,
  output logic [STATE_W-1:0]  new_s,
  output logic [REFRAC_W-1:0] new_r,
  output logic                spike
);

  // A refractory neuron always holds state 0 (cleared on the spike and only
  // leaked since), so gating the spike by r==0 changes nothing for thr>0 and
  // keeps refractory neurons silent when the threshold is programmed to 0.
  always_comb begin
    spike = (r == '0) && (s >= thr);
    new_s = s;
    new_r = r;
    if (spike) begin
      new_s = '0;
      new_r = REFRAC_W'(REFRAC_TICKS);
    end else if (r != '0) begin
      new_s = leak(s);
      new_r = r - REFRAC_W'(1);
    end else begin
      new_s = sat8(c, leak(s));
      new_r = '0;
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexes one lif_core across NUM_NEURONS neurons. A tick captures
// all currents and the active threshold, then one neuron is updated per clock;
// after the last neuron the spike vector is published with a done pulse.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    lif_scheduler_if slave modport (tick, current_in, cfg_we,
//          cfg_thresh, rd_sel in; busy, done, spike_vec, rd_state, overrun out)
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS  = 4,
  parameter int REFRAC_TICKS = 2,
  parameter int THRESH_RESET = 230
) (
  input  logic              clk,
  input  logic              rst_n,
  lif_scheduler_if.slave    bus
);

  localparam int                IDX_W    = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  lif_state_e                   fsm_q, fsm_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [STATE_W-1:0]           mem_q [NUM_NEURONS];
  logic [STATE_W-1:0]           mem_d [NUM_NEURONS];
  logic [REFRAC_W-1:0]          ref_q [NUM_NEURONS];
  logic [REFRAC_W-1:0]          ref_d [NUM_NEURONS];
  logic [8*NUM_NEURONS-1:0]     shadow_q, shadow_d;
  logic [STATE_W-1:0]           thresh_q, thresh_d;
  logic [STATE_W-1:0]           thr_ts_q, thr_ts_d;
  logic [NUM_NEURONS-1:0]       pending_q, pending_d;
  logic [NUM_NEURONS-1:0]       spike_vec_q, spike_vec_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         overrun_q, overrun_d;
  logic                         armed_q, armed_d;

  logic [STATE_W-1:0]           core_new_s;
  logic [REFRAC_W-1:0]          core_new_r;
  logic                         core_spike;

  lif_core #(
    .REFRAC_TICKS (REFRAC_TICKS)
  ) u_core (
    .s     (mem_q[idx_q]),
    .c     (shadow_q[{idx_q, 3'b000} +: 8]),
    .r     (ref_q[idx_q]),
    .thr   (thr_ts_q),
    .new_s (core_new_s),
    .new_r (core_new_r),
    .spike (core_spike)
  );

  // Next-state logic. armed_q stays low for the first edge after reset
  // release, so a tick coincident with the release edge is never accepted.
  // A threshold write in the same cycle as an accepted tick is forwarded
  // into the per-timestep copy; later writes only reach the active register.
  always_comb begin
    fsm_d       = fsm_q;
    idx_d       = idx_q;
    mem_d       = mem_q;
    ref_d       = ref_q;
    shadow_d    = shadow_q;
    thresh_d    = bus.cfg_we ? bus.cfg_thresh : thresh_q;
    thr_ts_d    = thr_ts_q;
    pending_d   = pending_q;
    spike_vec_d = spike_vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    armed_d     = 1'b1;

    unique case (fsm_q)
      IDLE: begin
        if (bus.tick && armed_q) begin
          fsm_d     = UPDATE;
          shadow_d  = bus.current_in;
          thr_ts_d  = thresh_d;
          idx_d     = '0;
          pending_d = '0;
          busy_d    = 1'b1;
        end
      end
      UPDATE: begin
        if (bus.tick) overrun_d = 1'b1;
        mem_d[idx_q]     = core_new_s;
        ref_d[idx_q]     = core_new_r;
        pending_d[idx_q] = core_spike;
        if (idx_q == LAST_IDX) begin
          fsm_d       = FINISH;
          spike_vec_d = pending_d;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      FINISH: begin
        if (bus.tick) overrun_d = 1'b1;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers. Outputs are registered, so done and busy change on the
  // edge that ends the last UPDATE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      idx_q       <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem_q[i] <= '0;
        ref_q[i] <= '0;
      end
      shadow_q    <= '0;
      thresh_q    <= STATE_W'(THRESH_RESET);
      thr_ts_q    <= STATE_W'(THRESH_RESET);
      pending_q   <= '0;
      spike_vec_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      idx_q       <= idx_d;
      mem_q       <= mem_d;
      ref_q       <= ref_d;
      shadow_q    <= shadow_d;
      thresh_q    <= thresh_d;
      thr_ts_q    <= thr_ts_d;
      pending_q   <= pending_d;
      spike_vec_q <= spike_vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      armed_q     <= armed_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.spike_vec = spike_vec_q;
  assign bus.overrun   = overrun_q;
  assign bus.rd_state  = mem_q[bus.rd_sel];

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler (NUM_NEURONS=4, REFRAC_TICKS=2,
// THRESH_RESET=230). Expected values come from a timestep-level model that
// applies the neuron update rules with integer arithmetic.
module tb_lif_scheduler;

  localparam int N      = 4;
  localparam int REFRAC = 2;
  localparam int THR0   = 230;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lif_scheduler_if #(.NUM_NEURONS(N)) bus ();

  lif_scheduler #(
    .NUM_NEURONS  (N),
    .REFRAC_TICKS (REFRAC),
    .THRESH_RESET (THR0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int       vectors     = 0;
  int       miscompares = 0;

  int       mState [N];
  int       mRef   [N];
  int       mThr;
  logic [N-1:0] mSpikes;
  logic     mOverrun;

  function automatic int leakRef(input int s);
    return s / 2 + s / 4 + s / 8;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mState[i] = 0;
      mRef[i]   = 0;
    end
    mThr     = THR0;
    mSpikes  = '0;
    mOverrun = 1'b0;
  endtask

  // One whole timestep of the network, computed from the neuron rules.
  task automatic modelTimestep(input logic [8*N-1:0] cur);
    int thrTs;
    int s;
    int c;
    int sum;
    thrTs = mThr;
    for (int i = 0; i < N; i++) begin
      s = mState[i];
      c = int'(cur[8*i +: 8]);
      mSpikes[i] = 1'b0;
      if (mRef[i] > 0) begin
        mState[i] = leakRef(s);
        mRef[i]   = mRef[i] - 1;
      end else if (s >= thrTs) begin
        mSpikes[i] = 1'b1;
        mState[i]  = 0;
        mRef[i]    = REFRAC;
      end else begin
        sum = c + leakRef(s);
        mState[i] = (sum > 255) ? 255 : sum;
      end
    end
  endtask

  task automatic checkAllStates(input string tag);
    for (int i = 0; i < N; i++) begin
      bus.rd_sel = 2'(i);
      #1;
      checkOutput($sformatf("%s_state%0d", tag, i), 32'(bus.rd_state), 32'(mState[i]));
    end
  endtask

  task automatic writeThresh(input logic [7:0] val);
    bus.cfg_we     = 1'b1;
    bus.cfg_thresh = val;
    nextCycle();
    bus.cfg_we     = 1'b0;
    mThr           = int'(val);
  endtask

  // Drives reset, checks reset values, then releases rst_n exactly on a
  // clock edge with tick held high; that tick must not start a timestep.
  task automatic resetDut(input string tag);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, "_busy"},    32'(bus.busy),      32'(0));
    checkOutput({tag, "_done"},    32'(bus.done),      32'(0));
    checkOutput({tag, "_spikes"},  32'(bus.spike_vec), 32'(0));
    checkOutput({tag, "_overrun"}, 32'(bus.overrun),   32'(0));
    checkAllStates(tag);
    nextCycle();
    bus.tick = 1'b1;
    bus.current_in = {N{8'd9}};
    @(posedge clk);
    rst_n = 1'b1;
    #1;
    bus.tick = 1'b0;
    nextCycle();
    checkOutput({tag, "_tick_at_release_busy"}, 32'(bus.busy), 32'(0));
    checkAllStates({tag, "_tick_at_release"});
  endtask

  // Runs one full timestep starting from IDLE. Optional events: a threshold
  // write with the tick, a threshold write during cycle midCfgCycle, and a
  // stray tick during cycle midTickCycle (cycle N+1 is the FINISH cycle).
  task automatic applyStimulus(input string name, input logic [8*N-1:0] cur,
                               input bit cfgAtTick, input logic [7:0] tickThr,
                               input int midCfgCycle, input logic [7:0] midThr,
                               input int midTickCycle);
    int oldState [N];
    for (int i = 0; i < N; i++) oldState[i] = mState[i];
    bus.tick       = 1'b1;
    bus.current_in = cur;
    if (cfgAtTick) begin
      bus.cfg_we     = 1'b1;
      bus.cfg_thresh = tickThr;
      mThr           = int'(tickThr);
    end
    modelTimestep(cur);
    nextCycle();
    bus.tick   = 1'b0;
    bus.cfg_we = 1'b0;
    for (int k = 1; k <= N + 1; k++) begin
      if (k <= N) begin
        bus.rd_sel = 2'(k - 1);
        #1;
        checkOutput($sformatf("%s_busy_c%0d", name, k), 32'(bus.busy), 32'(1));
        checkOutput($sformatf("%s_done_c%0d", name, k), 32'(bus.done), 32'(0));
        checkOutput($sformatf("%s_old_state%0d", name, k - 1), 32'(bus.rd_state),
                    32'(oldState[k - 1]));
      end else begin
        checkOutput({name, "_done_pulse"}, 32'(bus.done),      32'(1));
        checkOutput({name, "_busy_fin"},   32'(bus.busy),      32'(0));
        checkOutput({name, "_spikes"},     32'(bus.spike_vec), 32'(mSpikes));
      end
      if (k == midCfgCycle) begin
        bus.cfg_we     = 1'b1;
        bus.cfg_thresh = midThr;
        mThr           = int'(midThr);
      end
      if (k == midTickCycle) begin
        bus.tick = 1'b1;
        mOverrun = 1'b1;
      end
      nextCycle();
      bus.tick   = 1'b0;
      bus.cfg_we = 1'b0;
    end
    checkOutput({name, "_done_low"}, 32'(bus.done),    32'(0));
    checkOutput({name, "_overrun"},  32'(bus.overrun), 32'(mOverrun));
    checkAllStates(name);
  endtask

  initial begin
    logic [8*N-1:0] cur;
    logic [7:0]     thr;
    int             midCfg;
    int             midTick;
    bit             atTick;

    bus.tick       = 1'b0;
    bus.current_in = '0;
    bus.cfg_we     = 1'b0;
    bus.cfg_thresh = '0;
    bus.rd_sel     = '0;

    $display("[TB] reset and first timestep");
    resetDut("rst1");
    applyStimulus("ts1", {N{8'd100}}, 1'b0, 8'd0, 0, 8'd0, 0);

    $display("[TB] constant current, saturation, spike and refractory");
    for (int t = 2; t <= 7; t++)
      applyStimulus($sformatf("ts%0d", t), {N{8'd100}}, 1'b0, 8'd0, 0, 8'd0, 0);

    $display("[TB] mid-timestep threshold write and overrun");
    resetDut("rst2");
    applyStimulus("cfg_mid", {N{8'd100}}, 1'b0, 8'd0, 2, 8'd50, 2);
    applyStimulus("cfg_next", {N{8'd0}}, 1'b0, 8'd0, 0, 8'd0, 0);
    applyStimulus("tick_in_finish", {8'd5, 8'd60, 8'd7, 8'd40}, 1'b0, 8'd0, 0, 8'd0, N + 1);

    $display("[TB] saturation at threshold 255");
    resetDut("rst3");
    writeThresh(8'd255);
    applyStimulus("sat255_a", {N{8'd255}}, 1'b0, 8'd0, 0, 8'd0, 0);
    applyStimulus("sat255_b", {N{8'd1}}, 1'b0, 8'd0, 0, 8'd0, 0);
    resetDut("rst4");
    applyStimulus("sat200_a", {N{8'd200}}, 1'b0, 8'd0, 0, 8'd0, 0);
    applyStimulus("sat200_b", {N{8'd255}}, 1'b1, 8'd255, 0, 8'd0, 0);
    applyStimulus("sat200_c", {N{8'd3}}, 1'b0, 8'd0, 0, 8'd0, 0);
    applyStimulus("thr0", {N{8'd3}}, 1'b1, 8'd0, 0, 8'd0, 0);

    $display("[TB] asynchronous reset during UPDATE");
    applyStimulus("pre_rst", {8'd90, 8'd80, 8'd70, 8'd60}, 1'b1, 8'd200, 0, 8'd0, 3);
    bus.tick       = 1'b1;
    bus.current_in = {N{8'd77}};
    nextCycle();
    bus.tick = 1'b0;
    nextCycle();
    nextCycle();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_busy",    32'(bus.busy),      32'(0));
    checkOutput("midrst_done",    32'(bus.done),      32'(0));
    checkOutput("midrst_spikes",  32'(bus.spike_vec), 32'(0));
    checkOutput("midrst_overrun", 32'(bus.overrun),   32'(0));
    checkAllStates("midrst");
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput($sformatf("midrst_no_done%0d", k), 32'(bus.done), 32'(0));
    end
    rst_n = 1'b1;
    nextCycle();
    applyStimulus("post_rst", {N{8'd100}}, 1'b0, 8'd0, 0, 8'd0, 0);

    $display("[TB] randomized timesteps");
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++)
        cur[8*i +: 8] = 8'($urandom_range(0, 255));
      atTick  = ($urandom_range(0, 3) == 0);
      thr     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      midCfg  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N + 1)) : 0;
      midTick = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, N + 1)) : 0;
      applyStimulus($sformatf("rnd%0d", t), cur, atTick, thr, midCfg,
                    8'($urandom_range(0, 255)), midTick);
      if ($urandom_range(0, 5) == 0)
        writeThresh(8'($urandom_range(100, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
